// File: rtl/psum_accumulator_if.sv
// Product-in / partial-sum-out bundle between one PE and its accumulator.
// o_sat only exists when PSUM_SATURATE_EN is defined.
interface psum_accumulator_if #(
  parameter int IN_W  = 19,
  parameter int ACC_W = 24,
  parameter int CNT_W = 4
);
  logic             i_valid;
  logic             o_ready;
  logic [IN_W-1:0]  i_calculated;
  logic             i_skip;
  logic             i_flush;
  logic             o_valid;
  logic             i_ready;
  logic [ACC_W-1:0] o_psum;
  logic [CNT_W-1:0] o_skip_cnt;
  logic [CNT_W-1:0] o_beats;
`ifdef PSUM_SATURATE_EN
  logic             o_sat;

  modport slave (
    input  i_valid, i_calculated, i_skip, i_flush, i_ready,
    output o_ready, o_valid, o_psum, o_skip_cnt, o_beats, o_sat
  );
  modport master (
    output i_valid, i_calculated, i_skip, i_flush, i_ready,
    input  o_ready, o_valid, o_psum, o_skip_cnt, o_beats, o_sat
  );
`else
  modport slave (
    input  i_valid, i_calculated, i_skip, i_flush, i_ready,
    output o_ready, o_valid, o_psum, o_skip_cnt, o_beats
  );
  modport master (
    output i_valid, i_calculated, i_skip, i_flush, i_ready,
    input  o_ready, o_valid, o_psum, o_skip_cnt, o_beats
  );
`endif
endinterface

// File: rtl/psum_accumulator.sv
// Sums KERNEL_LEN PE products per window into a one-deep valid/ready result register.
// Define PSUM_SATURATE_EN for saturating adds and the sticky o_sat flag.
module psum_accumulator #(
  parameter int IN_W       = 19,
  parameter int ACC_W      = 24,
  parameter int KERNEL_LEN = 9,
  parameter int CNT_W      = $clog2(KERNEL_LEN + 1)
) (
  input  logic clk,
  input  logic rst,
  psum_accumulator_if.slave bus
);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(KERNEL_LEN - 1);

  logic signed [ACC_W-1:0] acc_q, acc_d, operand, sum;
  logic [CNT_W-1:0]        cnt_q, cnt_d, skip_q, skip_d, skip_inc;
  logic                    close_pend, acc_fire, close;
  logic                    vld_q;
  logic [ACC_W-1:0]        psum_q;
  logic [CNT_W-1:0]        oskip_q, beats_q;

  assign close_pend  = (cnt_q == LAST_BEAT) | bus.i_flush;
  assign bus.o_ready = !(close_pend & vld_q & !bus.i_ready);
  assign acc_fire    = bus.i_valid & bus.o_ready;
  assign close       = acc_fire & close_pend;

  assign operand  = bus.i_skip ? '0 : ACC_W'($signed(bus.i_calculated));
  assign skip_inc = CNT_W'(bus.i_skip);

`ifdef PSUM_SATURATE_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  logic signed [ACC_W-1:0] raw;
  logic                    clip, sat_q, sat_d, osat_q;

  // Overflow only possible when both addends share a sign the result lacks.
  assign raw  = acc_q + operand;
  assign clip = (acc_q[ACC_W-1] == operand[ACC_W-1]) && (raw[ACC_W-1] != acc_q[ACC_W-1]);
  assign sum  = clip ? (acc_q[ACC_W-1] ? SAT_MIN : SAT_MAX) : raw;
  assign bus.o_sat = osat_q;
`else
  assign sum = acc_q + operand;
`endif

  always_comb begin
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    skip_d = skip_q;
`ifdef PSUM_SATURATE_EN
    sat_d  = sat_q;
`endif
    if (close) begin
      acc_d  = '0;
      cnt_d  = '0;
      skip_d = '0;
`ifdef PSUM_SATURATE_EN
      sat_d  = 1'b0;
`endif
    end else if (acc_fire) begin
      acc_d  = sum;
      cnt_d  = cnt_q + CNT_W'(1);
      skip_d = skip_q + skip_inc;
`ifdef PSUM_SATURATE_EN
      sat_d  = sat_q | clip;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      acc_q   <= '0;
      cnt_q   <= '0;
      skip_q  <= '0;
      vld_q   <= 1'b0;
      psum_q  <= '0;
      oskip_q <= '0;
      beats_q <= '0;
`ifdef PSUM_SATURATE_EN
      sat_q   <= 1'b0;
      osat_q  <= 1'b0;
`endif
    end else begin
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      skip_q <= skip_d;
      // A closing beat reloads the result even on the edge the old one drains.
      if (close) begin
        vld_q   <= 1'b1;
        psum_q  <= sum;
        oskip_q <= skip_q + skip_inc;
        beats_q <= cnt_q + CNT_W'(1);
`ifdef PSUM_SATURATE_EN
        osat_q  <= sat_q | clip;
`endif
      end else if (bus.i_ready) begin
        vld_q <= 1'b0;
      end
    end
  end

  assign bus.o_valid    = vld_q;
  assign bus.o_psum     = psum_q;
  assign bus.o_skip_cnt = oskip_q;
  assign bus.o_beats    = beats_q;
endmodule
